button_debouncer: RTL and testbench



---
 rtl/button_debouncer.sv | 133 +++++++++++++
 tb/tb_button_debouncer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button conditioner: per channel a two-flop synchroniser, a
// consecutive-sample debounce FSM, a registered level and one-cycle press/release strobes.
module button_debouncer #(
  parameter int unsigned NBTN       = 5,
  parameter int unsigned DEBOUNCE   = 800000,
  parameter int unsigned CNTW       = 24,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_lvl,
  output logic [NBTN-1:0] btn_dn,
  output logic [NBTN-1:0] btn_up
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  logic [NBTN-1:0] pin;
  logic [NBTN-1:0] sync_meta;
  logic [NBTN-1:0] sync_q;

  // Polarity is normalised before synchronising so reset value 0 means released
  assign pin = btn_raw ^ {NBTN{ACTIVE_LOW}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= pin;
      sync_q    <= sync_meta;
    end
  end

  for (genvar g = 0; g < NBTN; g++) begin : g_ch
    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            lvl_q, lvl_d;
    logic            dn_q, dn_d;
    logic            up_q, up_d;
    logic            s;

    assign s = sync_q[g];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        dn_q    <= 1'b0;
        up_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        dn_q    <= dn_d;
        up_q    <= up_d;
      end
    end

    // cnt holds the number of consecutive samples that disagree with the accepted level
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      dn_d    = 1'b0;
      up_d    = 1'b0;
      case (state_q)
        RELEASED: begin
          if (s) begin
            state_d = PRESS_CHK;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d   = '0;
          end
        end
        PRESS_CHK: begin
          if (!s) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
            lvl_d   = 1'b1;
            dn_d    = 1'b1;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_d = RELEASE_CHK;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d   = '0;
          end
        end
        RELEASE_CHK: begin
          if (s) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = RELEASED;
            cnt_d   = '0;
            lvl_d   = 1'b0;
            up_d    = 1'b1;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
          lvl_d   = 1'b0;
        end
      endcase
    end

    assign btn_lvl[g] = lvl_q;
    assign btn_dn[g]  = dn_q;
    assign btn_up[g]  = up_q;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed vector table, hand sequences for reset,
// active-low pins and a wide counter, then random bouncing against a run-length model.
module tb_button_debouncer;

  localparam int unsigned NB   = 5;
  localparam int unsigned D    = 4;
  localparam int unsigned DBIG = 16383;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NB-1:0] raw;
  logic [NB-1:0] raw_n;
  logic          big_raw;
  logic [NB-1:0] hi_lvl, hi_dn, hi_up;
  logic [NB-1:0] lo_lvl, lo_dn, lo_up;
  logic          big_lvl, big_dn, big_up;

  assign raw_n = ~raw;

  button_debouncer #(.NBTN(NB), .DEBOUNCE(D), .CNTW(3), .ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst(rst), .btn_raw(raw), .btn_lvl(hi_lvl), .btn_dn(hi_dn), .btn_up(hi_up));

  button_debouncer #(.NBTN(NB), .DEBOUNCE(D), .CNTW(3), .ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst(rst), .btn_raw(raw_n), .btn_lvl(lo_lvl), .btn_dn(lo_dn), .btn_up(lo_up));

  button_debouncer #(.NBTN(1), .DEBOUNCE(DBIG), .CNTW(14), .ACTIVE_LOW(1'b0)) u_big (
    .clk(clk), .rst(rst), .btn_raw(big_raw), .btn_lvl(big_lvl), .btn_dn(big_dn), .btn_up(big_up));

  int n_cmp = 0;
  int n_err = 0;

  // Reference: pins reach the filter two edges late; a level flips once D
  // consecutive samples disagree with it.
  logic [NB-1:0] raw_q[$];
  logic [NB-1:0] m_lvl, m_dn, m_up;
  int unsigned   run[NB];

  typedef struct {
    logic [NB-1:0] raw;
    logic [NB-1:0] lvl;
    logic [NB-1:0] dn;
    logic [NB-1:0] up;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_q.delete();
    raw_q.push_back('0);
    raw_q.push_back('0);
    m_lvl = '0;
    m_dn  = '0;
    m_up  = '0;
    for (int ch = 0; ch < int'(NB); ch++) run[ch] = 0;
  endtask

  task automatic model_edge(input logic [NB-1:0] r);
    logic [NB-1:0] s;
    raw_q.push_back(r);
    s = raw_q.pop_front();
    m_dn = '0;
    m_up = '0;
    for (int ch = 0; ch < int'(NB); ch++) begin
      if (s[ch] != m_lvl[ch]) run[ch] = run[ch] + 1;
      else                    run[ch] = 0;
      if (run[ch] == D) begin
        m_lvl[ch] = s[ch];
        if (s[ch]) m_dn[ch] = 1'b1;
        else       m_up[ch] = 1'b1;
        run[ch] = 0;
      end
    end
  endtask

  task automatic step(input logic [NB-1:0] r);
    raw = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check("hi_lvl", hi_lvl, m_lvl);
    check("hi_dn",  hi_dn,  m_dn);
    check("hi_up",  hi_up,  m_up);
    check("lo_lvl", lo_lvl, m_lvl);
    check("lo_dn",  lo_dn,  m_dn);
    check("lo_up",  lo_up,  m_up);
  endtask

  // Asserts reset between clock edges and checks the outputs clear without a clock
  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_hi_lvl", hi_lvl, '0);
    check("rst_hi_dn",  hi_dn,  '0);
    check("rst_hi_up",  hi_up,  '0);
    check("rst_lo_lvl", lo_lvl, '0);
    check("rst_big",    {2'b0, big_lvl, big_dn, big_up}, '0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  function automatic void add_vec(input logic [NB-1:0] r, input logic [NB-1:0] l,
                                  input logic [NB-1:0] d, input logic [NB-1:0] u);
    vec_t v;
    v.raw = r;
    v.lvl = l;
    v.dn  = d;
    v.up  = u;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [NB-1:0] r;
    int            early;

    // Press ch0: accepted on the 6th edge, strobe lasts one cycle
    for (int i = 1; i <= 7; i++)
      add_vec(5'b00001, (i >= 6) ? 5'b00001 : 5'b00000, (i == 6) ? 5'b00001 : 5'b00000, 5'b00000);
    // Bounce on ch2 (1,1,0,1,1,0,0...) never reaches D samples
    add_vec(5'b00101, 5'b00001, 5'b0, 5'b0);
    add_vec(5'b00101, 5'b00001, 5'b0, 5'b0);
    add_vec(5'b00001, 5'b00001, 5'b0, 5'b0);
    add_vec(5'b00101, 5'b00001, 5'b0, 5'b0);
    add_vec(5'b00101, 5'b00001, 5'b0, 5'b0);
    for (int i = 0; i < 4; i++) add_vec(5'b00001, 5'b00001, 5'b0, 5'b0);
    // Press ch4
    for (int i = 1; i <= 7; i++)
      add_vec(5'b10001, (i >= 6) ? 5'b10001 : 5'b00001, (i == 6) ? 5'b10000 : 5'b00000, 5'b00000);
    // Release ch4 with a one-cycle glitch after two low cycles
    add_vec(5'b00001, 5'b10001, 5'b0, 5'b0);
    add_vec(5'b00001, 5'b10001, 5'b0, 5'b0);
    add_vec(5'b10001, 5'b10001, 5'b0, 5'b0);
    for (int i = 4; i <= 10; i++)
      add_vec(5'b00001, (i >= 9) ? 5'b00001 : 5'b10001, 5'b00000, (i == 9) ? 5'b10000 : 5'b00000);

    rst     = 1'b1;
    raw     = '0;
    big_raw = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("reset_lvl", hi_lvl, '0);
    check("reset_dn",  hi_dn,  '0);
    check("reset_up",  hi_up,  '0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].raw);
      check($sformatf("vec%0d_lvl", i), hi_lvl, vecs[i].lvl);
      check($sformatf("vec%0d_dn", i),  hi_dn,  vecs[i].dn);
      check($sformatf("vec%0d_up", i),  hi_up,  vecs[i].up);
    end

    // Reset while ch1 is mid-count; ch0 and ch1 held through release count as new presses
    for (int i = 0; i < 4; i++) step(5'b00011);
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(5'b00011);
      if (i == 5) check("t4_lvl_before", hi_lvl, 5'b00000);
      if (i == 6) check("t4_dn_after_rst", hi_dn, 5'b00011);
    end
    for (int i = 0; i < 8; i++) step(5'b00000);

    // Active-low pins idle at all ones; drop bits 0 and 3 together
    do_reset();
    for (int i = 0; i < 3; i++) step(5'b00000);
    check("t5_idle_lvl", lo_lvl, 5'b00000);
    for (int i = 1; i <= 6; i++) begin
      step(5'b01001);
      if (i == 5) check("t5_dn_early", lo_dn, 5'b00000);
      if (i == 6) begin
        check("t5_dn", lo_dn, 5'b01001);
        check("t5_lvl", lo_lvl, 5'b01001);
      end
    end
    step(5'b01001);
    check("t5_dn_one_cycle", lo_dn, 5'b00000);

    // Random bouncing on every channel, with one reset part way through
    r = 5'b01001;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < int'(NB); b++)
        if ($urandom_range(4, 0) == 0) r[b] = ~r[b];
      step(r);
      if (c == 300) do_reset();
    end

    // Wide counter at its top value: D-1 samples are rejected, D are accepted
    raw = '0;
    do_reset();
    early   = 0;
    big_raw = 1'b1;
    for (int i = 1; i < int'(DBIG); i++) begin
      step(5'b00000);
      if (big_lvl || big_dn) early++;
    end
    big_raw = 1'b0;
    step(5'b00000);
    if (big_lvl || big_dn) early++;
    big_raw = 1'b1;
    for (int i = 1; i <= int'(DBIG) + 2; i++) begin
      step(5'b00000);
      if (i <= int'(DBIG) + 1 && (big_lvl || big_dn)) early++;
      if (i == int'(DBIG) + 1) check("big_lvl_before", {4'b0, big_lvl}, 5'd0);
      if (i == int'(DBIG) + 2) begin
        check("big_lvl_after", {4'b0, big_lvl}, 5'd1);
        check("big_dn", {4'b0, big_dn}, 5'd1);
        check("big_up", {4'b0, big_up}, 5'd0);
      end
    end
    check("big_no_early_press", 5'(early), 5'd0);
    step(5'b00000);
    check("big_dn_one_cycle", {3'b0, big_lvl, big_dn}, 5'b00010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
